// File: rtl/sm_mac_accumulator_pkg.sv
// Shared definitions for the sign-magnitude MAC stage: FSM encodings and SM field helpers.
package sm_mac_accumulator_pkg;

    localparam int unsigned ST_W = 2;

    localparam logic [ST_W-1:0] S_CLR = 2'd0;
    localparam logic [ST_W-1:0] S_ACC = 2'd1;
    localparam logic [ST_W-1:0] S_OUT = 2'd2;

    // A zero magnitude always carries a positive sign, so -0 never propagates.
    function automatic logic sm_sign_fix(input logic sign, input logic mag_nz);
        return sign & mag_nz;
    endfunction

endpackage

// File: rtl/sm_mac_accumulator_if.sv
// Input pair stream and result stream of the sign-magnitude MAC stage.
interface sm_mac_accumulator_if #(
    parameter int unsigned DW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] x_in;
    logic [DW-1:0] w_in;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;

    modport master (
        output in_valid, x_in, w_in, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, x_in, w_in, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/sm_mac_accumulator_mul.sv
// Combinational sign-magnitude multiplier: DW-bit operands, (2*DW-1)-bit product.
module sm_mac_accumulator_mul
    import sm_mac_accumulator_pkg::*;
#(
    parameter int unsigned DW = 8
) (
    input  logic [DW-1:0]   i_a,
    input  logic [DW-1:0]   i_b,
    output logic [2*DW-2:0] o_prod_c
);
    localparam int unsigned MW = DW - 1;
    localparam int unsigned PW = 2 * MW;

    logic [PW-1:0] w_mag;

    assign w_mag    = PW'(i_a[MW-1:0]) * PW'(i_b[MW-1:0]);
    assign o_prod_c = {sm_sign_fix(i_a[DW-1] ^ i_b[DW-1], |w_mag), w_mag};

endmodule

// File: rtl/sm_mac_accumulator.sv
// Sequential sign-magnitude multiply-accumulate stage for one neuron.
// Optional build macro SM_MAC_RELU_EN: negative results are output as +0.
module sm_mac_accumulator
    import sm_mac_accumulator_pkg::*;
#(
    parameter int unsigned DW        = 8,
    parameter int unsigned ACC_W     = 16,
    parameter int unsigned N_INPUTS  = 4,
    parameter int unsigned FRAC_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sm_mac_accumulator_if.slave   io
);
    localparam int unsigned MW      = DW - 1;
    localparam int unsigned PW      = 2 * MW;
    localparam int unsigned AMW     = ACC_W - 1;
    localparam int unsigned CNT_W   = $clog2(N_INPUTS + 1);
    localparam int unsigned OUT_MAX = (32'd1 << MW) - 32'd1;

    logic [ST_W-1:0]  r_state,     w_state_nx;
    logic             r_acc_sign,  w_acc_sign_nx;
    logic [AMW-1:0]   r_acc_mag,   w_acc_mag_nx;
    logic [CNT_W-1:0] r_cnt,       w_cnt_nx;
    logic [DW-1:0]    r_out_data,  w_out_data_nx;
    logic             r_in_ready,  w_in_ready_nx;
    logic             r_out_valid, w_out_valid_nx;

    logic [PW:0]      w_prod;
    logic [AMW-1:0]   w_prod_mag;
    logic [AMW:0]     w_sum;
    logic             w_acc_sign_upd;
    logic [AMW-1:0]   w_acc_mag_upd;
    logic [AMW-1:0]   w_shift;
    logic [MW-1:0]    w_out_mag;
    logic             w_out_sign;
    logic [DW-1:0]    w_out_fmt;
    logic             w_accept;
    logic             w_last;

    sm_mac_accumulator_mul #(.DW(DW)) u_mul (
        .i_a      (io.x_in),
        .i_b      (io.w_in),
        .o_prod_c (w_prod)
    );

    assign w_prod_mag = AMW'(w_prod[PW-1:0]);
    assign w_sum      = (AMW+1)'(r_acc_mag) + (AMW+1)'(w_prod_mag);
    assign w_accept   = r_in_ready & io.in_valid;
    assign w_last     = (r_cnt == CNT_W'(N_INPUTS - 1));

    // Sign-magnitude add of the current product into the accumulator, saturating on overflow.
    always_comb begin
        w_acc_sign_upd = r_acc_sign;
        w_acc_mag_upd  = r_acc_mag;
        if (r_acc_sign == w_prod[PW]) begin
            w_acc_mag_upd  = w_sum[AMW] ? {AMW{1'b1}} : w_sum[AMW-1:0];
            w_acc_sign_upd = r_acc_sign;
        end else if (r_acc_mag >= w_prod_mag) begin
            w_acc_mag_upd  = r_acc_mag - w_prod_mag;
            w_acc_sign_upd = r_acc_sign;
        end else begin
            w_acc_mag_upd  = w_prod_mag - r_acc_mag;
            w_acc_sign_upd = w_prod[PW];
        end
        w_acc_sign_upd = sm_sign_fix(w_acc_sign_upd, |w_acc_mag_upd);
    end

    // Scale the updated accumulator down to the DW-bit result and saturate.
    always_comb begin
        w_shift    = w_acc_mag_upd >> FRAC_BITS;
        w_out_mag  = (w_shift > AMW'(OUT_MAX)) ? MW'(OUT_MAX) : w_shift[MW-1:0];
        w_out_sign = sm_sign_fix(w_acc_sign_upd, |w_out_mag);
`ifdef SM_MAC_RELU_EN
        w_out_fmt  = w_out_sign ? '0 : {1'b0, w_out_mag};
`else
        w_out_fmt  = {w_out_sign, w_out_mag};
`endif
    end

    // Next-state and next-register values for clear / accumulate / output phases.
    always_comb begin
        w_state_nx    = r_state;
        w_acc_sign_nx = r_acc_sign;
        w_acc_mag_nx  = r_acc_mag;
        w_cnt_nx      = r_cnt;
        w_out_data_nx = r_out_data;
        case (r_state)
            S_CLR: begin
                w_acc_sign_nx = 1'b0;
                w_acc_mag_nx  = '0;
                w_cnt_nx      = '0;
                w_state_nx    = S_ACC;
            end
            S_ACC: begin
                if (w_accept) begin
                    w_acc_sign_nx = w_acc_sign_upd;
                    w_acc_mag_nx  = w_acc_mag_upd;
                    w_cnt_nx      = r_cnt + CNT_W'(1);
                    if (w_last) begin
                        w_out_data_nx = w_out_fmt;
                        w_state_nx    = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (io.out_ready) begin
                    w_state_nx = S_CLR;
                end
            end
            default: begin
                w_state_nx = S_CLR;
            end
        endcase
        w_in_ready_nx  = (w_state_nx == S_ACC);
        w_out_valid_nx = (w_state_nx == S_OUT);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_CLR;
            r_acc_sign  <= 1'b0;
            r_acc_mag   <= '0;
            r_cnt       <= '0;
            r_out_data  <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_acc_sign  <= w_acc_sign_nx;
            r_acc_mag   <= w_acc_mag_nx;
            r_cnt       <= w_cnt_nx;
            r_out_data  <= w_out_data_nx;
            r_in_ready  <= w_in_ready_nx;
            r_out_valid <= w_out_valid_nx;
        end
    end

    assign io.in_ready  = r_in_ready;
    assign io.out_valid = r_out_valid;
    assign io.out_data  = r_out_data;

endmodule
